// File: rtl/can_pkg.sv
// Shared constants and types for the CAN bit-destuffing receiver.
package can_pkg;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int SAMPLE_POINT_DEF = 7;
  localparam int STUFF_LEN_DEF    = 5;
  localparam int FIXED_LEN_DEF    = 4;
  localparam int CNT_W_DEF        = 3;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DYN  = 2'd1,
    ST_FIX  = 2'd2
  } stuff_state_e;

  typedef enum logic [1:0] {
    BIT_DATA  = 2'd0,
    BIT_STUFF = 2'd1,
    BIT_ERROR = 2'd2
  } bit_kind_e;

endpackage

// File: rtl/can_bit_timing.sv
// RX synchroniser and nominal bit timing: phase counter with hard sync on a
// recessive-to-dominant edge while idle, and a sample-point strobe.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic hsync_en_i,
  output logic sample_o,
  output logic rx_o
);

  localparam int              PH_W      = $clog2(CLKS_PER_BIT);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_POINT);

  logic            meta_q;
  logic            rx_q;
  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic            fall_s;

  // Synchroniser flops and phase register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= RECESSIVE;
      rx_q    <= RECESSIVE;
      phase_q <= '0;
    end else begin
      meta_q  <= rx_i;
      rx_q    <= meta_q;
      phase_q <= phase_d;
    end
  end

  // Edge seen one stage early so phase 0 lines up with the first dominant rx_o cycle.
  assign fall_s = (rx_q == RECESSIVE) && (meta_q == DOMINANT);

  // Phase counter with hard sync.
  always_comb begin
    phase_d = phase_q;
    if (hsync_en_i && fall_s) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  assign sample_o = (phase_q == PH_SAMPLE);
  assign rx_o     = rx_q;

endmodule

// File: rtl/can_destuff_gen.sv
// Parametrised CAN bit destuffer: removes dynamic and fixed stuff bits, flags
// stuff errors and keeps a wrapping count of removed dynamic stuff bits.
module can_destuff_gen
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEF,
  parameter int STUFF_LEN    = STUFF_LEN_DEF,
  parameter int FIXED_LEN    = FIXED_LEN_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Rx_Serial,
  input  logic             i_Enable,
  input  logic             i_Fixed_Mode,
  output logic             o_Sample,
  output logic             o_Bit,
  output logic             o_Bit_Valid,
  output logic             o_Ignora_Bit,
  output logic             o_Eror_Stuffing,
  output logic [CNT_W-1:0] o_Stuff_Count
);

  localparam int               RUN_W    = $clog2(STUFF_LEN + 1);
  localparam int               FIX_W    = $clog2(FIXED_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUFF_LEN);
  localparam logic [FIX_W-1:0] FIX_LAST = FIX_W'(FIXED_LEN);

  logic             sample_s;
  logic             rx_s;
  stuff_state_e     state_q;
  stuff_state_e     state_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             last_q;
  logic             last_d;
  logic [FIX_W-1:0] fix_q;
  logic [FIX_W-1:0] fix_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bit_d;
  bit_kind_e        kind_s;

  can_bit_timing #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_timing (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .rx_i      (i_Rx_Serial),
    .hsync_en_i(~i_Enable),
    .sample_o  (sample_s),
    .rx_o      (rx_s)
  );

  // Stuffing state machine: classifies each sampled bit.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    fix_d   = fix_q;
    cnt_d   = cnt_q;
    kind_s  = BIT_DATA;
    bit_d   = sample_s ? rx_s : o_Bit;
    if (!i_Enable) begin
      state_d = ST_IDLE;
      run_d   = '0;
      last_d  = RECESSIVE;
      fix_d   = '0;
      cnt_d   = '0;
    end else if (sample_s) begin
      last_d = rx_s;
      if (i_Fixed_Mode) begin
        state_d = ST_FIX;
        run_d   = '0;
        // Entering the fixed field always starts with a stuff bit.
        if ((state_q != ST_FIX) || (fix_q == FIX_LAST)) begin
          fix_d  = '0;
          kind_s = (rx_s != last_q) ? BIT_STUFF : BIT_ERROR;
        end else begin
          fix_d  = fix_q + FIX_W'(1);
          kind_s = BIT_DATA;
        end
      end else begin
        state_d = ST_DYN;
        fix_d   = '0;
        if (run_q != RUN_MAX) begin
          kind_s = BIT_DATA;
          run_d  = (rx_s == last_q) ? (run_q + RUN_W'(1)) : RUN_W'(1);
        end else if (rx_s != last_q) begin
          kind_s = BIT_STUFF;
          run_d  = RUN_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          kind_s = BIT_ERROR;
          run_d  = '0;
        end
      end
    end else begin
      kind_s = BIT_DATA;
    end
  end

  // State and registered output strobes.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q         <= ST_IDLE;
      run_q           <= '0;
      last_q          <= RECESSIVE;
      fix_q           <= '0;
      cnt_q           <= '0;
      o_Sample        <= 1'b0;
      o_Bit           <= 1'b0;
      o_Bit_Valid     <= 1'b0;
      o_Ignora_Bit    <= 1'b0;
      o_Eror_Stuffing <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      last_q          <= last_d;
      fix_q           <= fix_d;
      cnt_q           <= cnt_d;
      o_Sample        <= sample_s;
      o_Bit           <= bit_d;
      o_Bit_Valid     <= sample_s && (kind_s == BIT_DATA);
      o_Ignora_Bit    <= sample_s && (kind_s == BIT_STUFF);
      o_Eror_Stuffing <= sample_s && (kind_s == BIT_ERROR);
    end
  end

  assign o_Stuff_Count = cnt_q;

endmodule

// File: tb/tb_can_destuff_gen.sv
// Directed bench for can_destuff_gen: hard sync, dynamic/fixed destuffing,
// stuff errors, counter wrap and mid-frame reset.
module tb_can_destuff_gen;

  localparam int         CPB = 10;
  localparam logic [2:0] K_V = 3'b100;
  localparam logic [2:0] K_I = 3'b010;
  localparam logic [2:0] K_E = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       en  = 1'b0;
  logic       fx  = 1'b0;
  logic       o_smp;
  logic       o_bit;
  logic       o_v;
  logic       o_ig;
  logic       o_er;
  logic [2:0] o_cnt;
  int         checks = 0;
  int         errors = 0;
  int         first;
  logic [3:0] sof;

  can_destuff_gen #(
    .CLKS_PER_BIT(10),
    .SAMPLE_POINT(7),
    .STUFF_LEN   (5),
    .FIXED_LEN   (4),
    .CNT_W       (3)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .i_Enable       (en),
    .i_Fixed_Mode   (fx),
    .o_Sample       (o_smp),
    .o_Bit          (o_bit),
    .o_Bit_Valid    (o_v),
    .o_Ignora_Bit   (o_ig),
    .o_Eror_Stuffing(o_er),
    .o_Stuff_Count  (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, o_cnt}, {29'd0, exp});
  endtask

  // One nominal bit; optional one-clock reset at window clock rst_idx (0 = none).
  task automatic send_bit(input string tag, input logic b, input logic [2:0] kind, input int rst_idx);
    int         nsmp  = 0;
    logic       sb    = 1'b0;
    logic [2:0] fl    = 3'b000;
    logic       stray = 1'b0;
    rx = b;
    for (int i = 1; i <= CPB; i++) begin
      if (i == rst_idx) rst = 1'b1;
      @(posedge clk); #1;
      if (i == rst_idx) begin
        rst = 1'b0;
        check({tag, "_reset_outs"}, {24'd0, o_smp, o_bit, o_v, o_ig, o_er, o_cnt}, 32'd0);
      end
      if (o_smp) begin
        nsmp++;
        sb = o_bit;
        fl = {o_v, o_ig, o_er};
      end else if ({o_v, o_ig, o_er} != 3'b000) begin
        stray = 1'b1;
      end
    end
    check(tag, {23'd0, 4'(nsmp), sb, fl, stray}, {23'd0, 4'd1, b, kind, 1'b0});
  endtask

  task automatic send_n(input string tag, input logic b, input logic [2:0] kind, input int n);
    for (int k = 0; k < n; k++) send_bit(tag, b, kind, 0);
  endtask

  // Four more equal bits completing a run of five, then the opposite stuff bit.
  task automatic stuff_group(input string tag, input logic v);
    send_n(tag, v, K_V, 4);
    send_bit({tag, "_stuff"}, ~v, K_I, 0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b0; fx = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outs", {24'd0, o_smp, o_bit, o_v, o_ig, o_er, o_cnt}, 32'd0);
    rst = 1'b0;

    // Falling edge 3 clocks into the bit; sample strobe must follow 10 clocks later.
    repeat (3) @(posedge clk); #1;
    rx    = 1'b0;
    first = 0;
    sof   = 4'h0;
    for (int i = 1; i <= CPB; i++) begin
      @(posedge clk); #1;
      if (o_smp && (first == 0)) begin
        first = i;
        sof   = {o_bit, o_v, o_ig, o_er};
      end
    end
    check("hard_sync_latency", first, 32'd10);
    check("idle_sample_valid", {28'd0, sof}, {28'd0, 4'b0100});

    // Dynamic stuffing: 0x5, stuff 1, data 0.
    en = 1'b1;
    send_n("dyn_zeros", 1'b0, K_V, 5);
    send_bit("dyn_stuff1", 1'b1, K_I, 0);
    send_bit("dyn_after", 1'b0, K_V, 0);
    check_cnt("cnt_after_first_stuff", 3'd1);

    // Stuff bit counts as bit 1 of the following run.
    stuff_group("run_g0", 1'b0);
    stuff_group("run_g1", 1'b1);
    check_cnt("cnt_after_runs", 3'd3);

    // Six equal bits: error on the sixth, then a fresh run of five plus stuff.
    send_n("err_ones", 1'b1, K_V, 5);
    send_bit("err_sixth", 1'b1, K_E, 0);
    check_cnt("cnt_after_error", 3'd3);
    send_n("err_rerun", 1'b1, K_V, 5);
    send_bit("err_rerun_stuff", 1'b0, K_I, 0);
    check_cnt("cnt_before_fixed", 3'd4);

    // Fixed stuffing after a last bit of 1.
    send_bit("pre_fixed", 1'b1, K_V, 0);
    fx = 1'b1;
    send_bit("fix_first_stuff", 1'b0, K_I, 0);
    send_bit("fix_d1", 1'b1, K_V, 0);
    send_bit("fix_d2", 1'b0, K_V, 0);
    send_bit("fix_d3", 1'b1, K_V, 0);
    send_bit("fix_d4", 1'b1, K_V, 0);
    send_bit("fix_stuff2", 1'b0, K_I, 0);
    send_bit("fix_d5", 1'b0, K_V, 0);
    send_bit("fix_d6", 1'b0, K_V, 0);
    send_bit("fix_d7", 1'b1, K_V, 0);
    send_bit("fix_d8", 1'b0, K_V, 0);
    send_bit("fix_bad_stuff", 1'b0, K_E, 0);
    check_cnt("cnt_held_in_fixed", 3'd4);

    // Leaving fixed mode restarts the run from zero.
    fx = 1'b0;
    send_n("post_fixed", 1'b0, K_V, 5);
    send_bit("post_fixed_stuff", 1'b1, K_I, 0);
    check_cnt("cnt_5", 3'd5);

    // Counter wraps 7 -> 0.
    stuff_group("wrap_a", 1'b1);
    check_cnt("cnt_6", 3'd6);
    stuff_group("wrap_b", 1'b0);
    check_cnt("cnt_7", 3'd7);
    stuff_group("wrap_c", 1'b1);
    check_cnt("cnt_wrap_0", 3'd0);

    // Mid-frame reset after three equal bits.
    stuff_group("pre_rst", 1'b0);
    check_cnt("cnt_before_reset", 3'd1);
    send_n("pre_rst_ones", 1'b1, K_V, 2);
    send_bit("rst_bit", 1'b1, K_V, 2);
    send_n("post_rst_ones", 1'b1, K_V, 4);
    send_bit("post_rst_stuff", 1'b0, K_I, 0);
    check_cnt("cnt_after_reset", 3'd1);

    // Disabled: every sample is data and the count is cleared.
    en = 1'b0;
    send_n("idle_zeros", 1'b0, K_V, 6);
    check_cnt("cnt_idle", 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_destuff_gen.md
Name: can_destuff_gen

Overview:
Parametrised CAN bit-destuffing receiver that succeeds the fixed 10-clock destuffer.
- Synchronises the raw RX line and recovers bit timing with hard sync and a configurable sample point.
- Removes dynamic stuff bits (classic CAN / CAN FD arbitration and data) and fixed stuff bits (CAN FD CRC field).
- Flags stuff errors and keeps a modulo stuff-bit count for the CAN FD stuff-count field.
- Sits between the RX pin and the frame decoder FSM.

Parameters:
CLKS_PER_BIT, 10, clocks per nominal bit; minimum 4.
SAMPLE_POINT, 7, clock index within the bit (0..CLKS_PER_BIT-1) at which RX is sampled.
STUFF_LEN, 5, equal consecutive bits that force a dynamic stuff bit.
FIXED_LEN, 4, data bits between fixed stuff bits in fixed mode.
CNT_W, 3, width of the dynamic stuff-bit counter; wraps modulo 2^CNT_W.

Ports:
i_Clock  in  1  single clock; all logic on its rising edge
i_Reset  in  1  synchronous, active-high reset
i_Rx_Serial  in  1  raw CAN RX line (asynchronous); 0 = dominant
i_Enable  in  1  1 = frame in progress, destuffing active; 0 = idle, hard sync armed
i_Fixed_Mode  in  1  1 = fixed stuffing (CRC field); 0 = dynamic stuffing
o_Sample  out  1  one-clock strobe in the cycle after each sample point
o_Bit  out  1  sampled bit value, valid while o_Sample = 1
o_Bit_Valid  out  1  one-clock strobe: o_Bit is a data bit
o_Ignora_Bit  out  1  one-clock strobe: o_Bit was a correct stuff bit and is dropped
o_Eror_Stuffing  out  1  one-clock strobe: stuff rule violated at this bit
o_Stuff_Count  out  CNT_W  dynamic stuff bits removed since i_Enable rose, modulo 2^CNT_W

Behaviour:
- Reset values:
  - All outputs 0.
  - Bit-phase counter 0.
  - Run length 0; last bit 1 (recessive).
  - Fixed counter 0.
  - Both synchroniser flops 1.
- i_Reset has priority over every other event, including mid-bit and mid-frame.
- Input path: 2-FF synchroniser giving rx_s, 2 clocks of latency.
- Bit timing:
  - Phase counter counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - While i_Enable = 0, a 1->0 edge on rx_s forces the phase to 0 on the next clock (hard sync).
  - No resync while i_Enable = 1.
  - Sample point is the cycle where phase == SAMPLE_POINT.
  - All strobes are registered and appear exactly one clock later; at most one of o_Bit_Valid, o_Ignora_Bit, o_Eror_Stuffing is high.
- i_Enable = 0:
  - o_Sample and o_Bit still run.
  - o_Bit_Valid is set on every sample; o_Ignora_Bit and o_Eror_Stuffing stay 0.
  - Run length 0, fixed counter 0, o_Stuff_Count 0.
- Dynamic mode (i_Enable = 1, i_Fixed_Mode = 0):
  - If run < STUFF_LEN: bit is data. If it equals the last bit, run++; otherwise run = 1. Last bit = sampled bit.
  - If run == STUFF_LEN and the bit differs from the last bit: o_Ignora_Bit pulses, run = 1, last = bit, o_Stuff_Count++ (wraps).
  - If run == STUFF_LEN and the bit equals the last bit: o_Eror_Stuffing pulses, run = 0, and the next bit starts a new run.
  - A stuff bit counts as bit 1 of the following run.
- Fixed mode (i_Fixed_Mode = 1):
  - The first sample after i_Fixed_Mode goes 0->1 is a fixed stuff bit.
  - After that, a stuff bit follows every FIXED_LEN data bits (fixed counter 0..FIXED_LEN, cleared on each stuff bit).
  - Expected stuff value is the complement of the last bit.
  - Match: o_Ignora_Bit pulses. Mismatch: o_Eror_Stuffing pulses. In both cases the bit is dropped and the count restarts.
  - o_Stuff_Count is held.
  - On i_Fixed_Mode 1->0, the fixed counter clears and run = 0.
  - Mode is evaluated at the sample point; a change between sample points applies from the next one.
- i_Enable falling mid-frame: all counters clear on the next clock; a pending strobe from a sample in the same cycle is still emitted.

Decomposition:
- Package can_pkg: default CLKS_PER_BIT, STUFF_LEN (5), FIXED_LEN (4), CNT_W (3), and a dominant/recessive bit-value constant.
- Sub-module can_bit_timing: synchroniser, phase counter, hard sync, sample strobe.
- The stuffing FSM stays in the top module.

Test Plan:
Use CLKS_PER_BIT = 10 and SAMPLE_POINT = 7 unless stated.
- Dynamic stuff removal: with i_Enable = 1, send bits 0,0,0,0,0,1,0 -> 5 o_Bit_Valid with 0, one o_Ignora_Bit at bit 6, o_Bit_Valid with 0 at bit 7, o_Stuff_Count = 1.
- Stuff bit starts a run: send 0×5, 1, 1×4, 0 -> o_Ignora_Bit at bits 6 and 11, o_Bit_Valid for the four 1s, no error.
- Stuff error: send 1×6 -> 5 o_Bit_Valid, o_Eror_Stuffing at bit 6; the following 1×5 then 0 yields o_Ignora_Bit.
- Fixed mode: raise i_Fixed_Mode after last bit 1; send 0,1,0,1,1,0,0,0,1 -> o_Ignora_Bit at bits 1 and 6, o_Eror_Stuffing at bit 6 when it is sent as 1 (complement expected 0), o_Stuff_Count unchanged.
- Hard sync and latency: with i_Enable = 0, apply a 1->0 edge 3 clocks into a bit -> o_Sample exactly 2+7+1 = 10 clocks after the edge; o_Stuff_Count wraps 7->0 after 8 stuff bits.
- Reset mid-frame: i_Reset for 1 clock after 3 equal bits -> all outputs 0 on the next clock, run restarts, no stuff expected until 5 new equal bits.
